sync_fifo: RTL and testbench

Single-clock, first-word-fall-through FIFO that buffers DATA_WIDTH-bit words between an input producer and a downstream consumer. Storage depth is parameterized and need not be a power of two. It provides active-low full/empty status flags and a synchronous clear.

---
 rtl/fifo_pkg.sv | 12 +
 rtl/fifo_mem.sv | 27 ++
 rtl/sync_fifo.sv | 100 ++++++++++
 tb/tb_sync_fifo.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared defaults and pointer helpers for the sync_fifo codebase slice.
// Pointer wrap handles depths that are not a power of two.
package fifo_pkg;

  localparam int DATA_WIDTH_DEFAULT = 11;
  localparam int FIFO_DEPTH_DEFAULT = 3;

  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array: one synchronous write port, one async read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int DEPTH      = FIFO_DEPTH_DEFAULT,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: storage has no reset; entries are only read after being written,
  // and leaving it out lets the array map onto plain flops or distributed RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo.sv
// First-word-fall-through single-clock FIFO with registered dout and flags.
// Define FIFO_COUNT_EN to expose the registered occupancy on the count port.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_WIDTH_DEFAULT,
  parameter int FIFO_DEPTH    = FIFO_DEPTH_DEFAULT,
  parameter int COUNTER_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,   // synchronous, active-high despite the name
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  enq,
  input  logic                  valid,
  output logic                  full_n,
  output logic [DATA_WIDTH-1:0] dout,
  input  logic                  deq,
  output logic                  empty_n,
  input  logic                  clr
`ifdef FIFO_COUNT_EN
  ,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  // COUNTER_WIDTH is a legacy parameter only; all sizing derives from FIFO_DEPTH.
  if (COUNTER_WIDTH < 0) begin : g_legacy_counter_width
  end

  logic [PW-1:0]         wptr, rptr, wptr_nxt, rptr_nxt;
  logic [CW-1:0]         count_q, count_nxt;
  logic                  wr_fire, rd_fire, mem_wr_en;
  logic [DATA_WIDTH-1:0] mem_rd_data, head_nxt;

  // NOTE: every signal gets a default before any branch so no latch is inferred.
  always_comb begin
    wr_fire   = enq & valid & full_n;
    rd_fire   = deq & empty_n;
    wptr_nxt  = wptr;
    rptr_nxt  = rptr;
    count_nxt = count_q;
    if (wr_fire) wptr_nxt = PW'(ptr_inc(32'(wptr), FIFO_DEPTH));
    if (rd_fire) rptr_nxt = PW'(ptr_inc(32'(rptr), FIFO_DEPTH));
    case ({wr_fire, rd_fire})
      2'b10:   count_nxt = count_q + CW'(1);
      2'b01:   count_nxt = count_q - CW'(1);
      default: count_nxt = count_q;
    endcase
    // The new head may be the word being written this edge, not yet in the array.
    head_nxt  = (wr_fire && (rptr_nxt == wptr)) ? din : mem_rd_data;
    mem_wr_en = wr_fire & ~clr & ~rst_n;
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH),
    .ADDR_WIDTH (PW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (mem_wr_en),
    .wr_addr (wptr),
    .wr_data (din),
    .rd_addr (rptr_nxt),
    .rd_data (mem_rd_data)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
      dout    <= '0;
      empty_n <= 1'b0;
      full_n  <= 1'b1;
    end else if (clr) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
      empty_n <= 1'b0;
      full_n  <= 1'b1;
    end else begin
      wptr    <= wptr_nxt;
      rptr    <= rptr_nxt;
      count_q <= count_nxt;
      empty_n <= (count_nxt != '0);
      full_n  <= (count_nxt != CW'(FIFO_DEPTH));
      if (count_nxt != '0) dout <= head_nxt;
    end
  end

`ifdef FIFO_COUNT_EN
  assign count = count_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: queue-based reference model compared every
// cycle, plus directed vectors with hand-computed expectations.
module tb_sync_fifo;

  localparam int DW    = 11;
  localparam int DEPTH = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [DW-1:0] din = '0;
  logic          enq = 1'b0, valid = 1'b0, deq = 1'b0, clr = 1'b0;
  logic          full_n, empty_n;
  logic [DW-1:0] dout;
`ifdef FIFO_COUNT_EN
  logic [$clog2(DEPTH+1)-1:0] count;
`endif

  int total = 0;
  int bad   = 0;
  bit checking = 1'b0;

  sync_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .COUNTER_WIDTH(1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     (din),
    .enq     (enq),
    .valid   (valid),
    .full_n  (full_n),
    .dout    (dout),
    .deq     (deq),
    .empty_n (empty_n),
    .clr     (clr)
`ifdef FIFO_COUNT_EN
    ,
    .count   (count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: contents as a queue, dout as the last non-empty head.
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] model_dout = '0;
  int            model_sz;
  bit            do_wr, do_rd;

  always @(posedge clk) begin
    if (rst_n) begin
      model_q.delete();
      model_dout = '0;
    end else if (clr) begin
      model_q.delete();
    end else begin
      model_sz = model_q.size();
      do_wr = enq && valid && (model_sz < DEPTH);
      do_rd = deq && (model_sz > 0);
      if (do_rd) void'(model_q.pop_front());
      if (do_wr) model_q.push_back(din);
      if (model_q.size() > 0) model_dout = model_q[0];
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("cyc_empty_n", 32'(empty_n), 32'(model_q.size() != 0));
      check("cyc_full_n",  32'(full_n),  32'(model_q.size() != DEPTH));
      check("cyc_dout",    32'(dout),    32'(model_dout));
`ifdef FIFO_COUNT_EN
      check("cyc_count",   32'(count),   32'(model_q.size()));
`endif
    end
  end

  task automatic apply(input logic e, input logic v, input logic d, input logic c,
                       input logic [DW-1:0] di);
    enq = e; valid = v; deq = d; clr = c; din = di;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    checking = 1'b1;
    rst_n = 1'b0;
    check("rst_empty_n", 32'(empty_n), 32'd0);
    check("rst_full_n",  32'(full_n),  32'd1);
    check("rst_dout",    32'(dout),    32'd0);

    // Fill to depth
    apply(1, 1, 0, 0, 11'd0);
    check("fill1_empty_n", 32'(empty_n), 32'd1);
    check("fill1_dout",    32'(dout),    32'd0);
    apply(1, 1, 0, 0, 11'd1);
    apply(1, 1, 0, 0, 11'd2);
    check("fill3_full_n", 32'(full_n), 32'd0);
    check("fill3_dout",   32'(dout),   32'd0);

    // Drain
    apply(0, 0, 1, 0, 11'd0);
    check("drain1_dout",   32'(dout),   32'd1);
    check("drain1_full_n", 32'(full_n), 32'd1);
    apply(0, 0, 1, 0, 11'd0);
    check("drain2_dout", 32'(dout), 32'd2);
    apply(0, 0, 1, 0, 11'd0);
    check("drain3_empty_n", 32'(empty_n), 32'd0);
    check("drain3_dout",    32'(dout),    32'd2);

    // Clear, with an enq in the same cycle that must be discarded
    apply(1, 1, 0, 0, 11'd3);
    check("clr_pre_empty_n", 32'(empty_n), 32'd1);
    check("clr_pre_dout",    32'(dout),    32'd3);
    apply(1, 1, 0, 1, 11'd7);
    check("clr_empty_n", 32'(empty_n), 32'd0);
    check("clr_full_n",  32'(full_n),  32'd1);
    check("clr_dout",    32'(dout),    32'd3);

    // Concurrent read and write at occupancy 1
    apply(1, 1, 0, 0, 11'd4);
    check("conc_w_dout", 32'(dout), 32'd4);
    apply(1, 1, 1, 0, 11'd5);
    check("conc_rw_dout",    32'(dout),    32'd5);
    check("conc_rw_empty_n", 32'(empty_n), 32'd1);
    apply(0, 0, 1, 0, 11'd0);
    check("conc_r_empty_n", 32'(empty_n), 32'd0);
    check("conc_r_dout",    32'(dout),    32'd5);

    // enq without valid is not a write
    apply(1, 0, 0, 0, 11'h7ff);
    check("novalid_empty_n", 32'(empty_n), 32'd0);

    // Overflow: 4th write ignored, also when deq is asserted while full
    apply(1, 1, 0, 0, 11'd6);
    apply(1, 1, 0, 0, 11'd7);
    apply(1, 1, 0, 0, 11'd8);
    check("ovf_full_n", 32'(full_n), 32'd0);
    check("ovf_dout",   32'(dout),   32'd6);
    apply(1, 1, 0, 0, 11'd9);
    check("ovf_ign_full_n", 32'(full_n), 32'd0);
    check("ovf_ign_dout",   32'(dout),   32'd6);
    apply(1, 1, 1, 0, 11'h55);
    check("ovf_rw_full_n", 32'(full_n), 32'd1);
    check("ovf_rw_dout",   32'(dout),   32'd7);
    apply(0, 0, 1, 0, 11'd0);
    check("ovf_drain_dout", 32'(dout), 32'd8);
    apply(0, 0, 1, 0, 11'd0);
    check("ovf_drain_empty_n", 32'(empty_n), 32'd0);
    check("ovf_drain_dout2",   32'(dout),    32'd8);

    // Underflow: deq on empty changes nothing
    apply(0, 0, 1, 0, 11'd0);
    check("udf_empty_n", 32'(empty_n), 32'd0);
    check("udf_full_n",  32'(full_n),  32'd1);
    check("udf_dout",    32'(dout),    32'd8);

    // Mixed traffic, checked against the model every cycle
    for (int i = 0; i < 60; i++) begin
      apply(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0),
            11'($urandom_range(0, 2047)));
    end
    apply(0, 0, 0, 0, 11'd0);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
